// File: rtl/jump_motion_ctrl.sv
// jump_motion_ctrl: per-frame player motion controller for the Doodle Jump core.
// Sequences the player through IDLE / RISE / FALL / DEAD, integrates gravity and
// horizontal input, and lands or re-bounces the player from the platform
// detector's hit/floor result.
// Optional feature macro: JUMP_SCROLL_EN (camera scroll clamp while rising).
module jump_motion_ctrl #(
  parameter int MAP_W       = 640,
  parameter int MAP_H       = 480,
  parameter int PLYR_H      = 32,
  parameter int JUMP_V      = 12,
  parameter int GRAV_DIV    = 4,
  parameter int X_STEP      = 3,
  parameter int START_X     = 304,
  parameter int START_Y     = 400,
  parameter int SCROLL_LINE = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  input  logic [9:0] floor,
  output logic [9:0] plyr_x,
  output logic [9:0] plyr_y,
  output logic [3:0] spd_x,
  output logic [3:0] spd_y,
  output logic [1:0] state,
  output logic       dir,
  output logic       fly,
  output logic       bounce,
  output logic       game_over,
  output logic [9:0] scroll_dy
);

  // Gravity counter is at least one bit wide so GRAV_DIV == 1 still elaborates.
  localparam int              GW         = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [GW-1:0]   GCNT_LAST  = GW'(GRAV_DIV - 1);
  localparam logic [GW-1:0]   GCNT_ONE   = GW'(1);
  localparam logic [9:0]      MAP_W10    = 10'(MAP_W);
  localparam logic [10:0]     MAP_W11    = 11'(MAP_W);
  localparam logic [10:0]     MAP_H11    = 11'(MAP_H);
  localparam logic [9:0]      PLYR_H10   = 10'(PLYR_H);
  localparam logic [10:0]     PLYR_H11   = 11'(PLYR_H);
  localparam logic [9:0]      DEAD_Y10   = 10'(MAP_H - PLYR_H);
  localparam logic [3:0]      JUMP_V4    = 4'(JUMP_V);
  localparam logic [3:0]      X_STEP4    = 4'(X_STEP);
  localparam logic [9:0]      X_STEP10   = 10'(X_STEP);
  localparam logic [10:0]     X_STEP11   = 11'(X_STEP);
  localparam logic [9:0]      START_X10  = 10'(START_X);
  localparam logic [9:0]      START_Y10  = 10'(START_Y);

  // Elaboration-time sanity checks on the configuration.
  if (GRAV_DIV < 1) begin : g_bad_grav_div
    $error("jump_motion_ctrl: GRAV_DIV must be at least 1");
  end
  if (SCROLL_LINE < 0 || SCROLL_LINE >= MAP_H) begin : g_bad_scroll_line
    $error("jump_motion_ctrl: SCROLL_LINE must lie inside the playfield");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RISE = 2'b01,
    S_FALL = 2'b10,
    S_DEAD = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      plyr_x_q, plyr_x_d;
  logic [9:0]      plyr_y_q, plyr_y_d;
  logic [3:0]      spd_x_q, spd_x_d;
  logic [3:0]      spd_y_q, spd_y_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            dir_q, dir_d;
  logic            bounce_q, bounce_d;

  // Horizontal candidates: wrap around the playfield in either direction.
  logic [10:0] x_right_sum;
  logic [9:0]  x_right;
  logic [9:0]  x_left;

  assign x_right_sum = {1'b0, plyr_x_q} + X_STEP11;
  // When wrapping, the true result is below MAP_W, so 10-bit modular math is exact.
  assign x_right = (x_right_sum >= MAP_W11) ? (plyr_x_q + X_STEP10 - MAP_W10)
                                            : (plyr_x_q + X_STEP10);
  assign x_left  = (plyr_x_q < X_STEP10)    ? (plyr_x_q + MAP_W10 - X_STEP10)
                                            : (plyr_x_q - X_STEP10);

  // Vertical candidates. y grows downward; sums carry an 11th bit so the
  // death test near the bottom edge cannot overflow.
  logic [9:0]  y_rise;
  logic [10:0] y_fall_sum;
  logic        fall_dead;
  logic [9:0]  y_land;

  assign y_rise     = (plyr_y_q < {6'b0, spd_y_q}) ? 10'd0 : (plyr_y_q - {6'b0, spd_y_q});
  assign y_fall_sum = {1'b0, plyr_y_q} + {7'b0, spd_y_q};
  assign fall_dead  = (y_fall_sum + PLYR_H11) >= MAP_H11;
  // Player stands on the platform: top = platform y minus sprite height.
  assign y_land     = (floor < PLYR_H10) ? 10'd0 : (floor - PLYR_H10);

  // Gravity helpers: speed changes once every GRAV_DIV frames.
  logic          gcnt_last;
  logic [GW-1:0] gcnt_inc;
  logic [3:0]    spd_y_dec;
  logic [3:0]    spd_y_inc;

  assign gcnt_last = (gcnt_q == GCNT_LAST);
  assign gcnt_inc  = gcnt_q + GCNT_ONE;
  assign spd_y_dec = spd_y_q - 4'd1;
  assign spd_y_inc = (spd_y_q == 4'hF) ? 4'hF : (spd_y_q + 4'd1);

`ifdef JUMP_SCROLL_EN
  localparam logic [9:0]  SCROLL_LINE10 = 10'(SCROLL_LINE);
  localparam logic [10:0] SCROLL_LINE11 = 11'(SCROLL_LINE);

  logic [9:0] scroll_dy_q, scroll_dy_d;
  logic       scroll_clamp;
  logic [9:0] scroll_amt;

  // Clamp when the rise step would carry the player above the scroll line;
  // the overshoot becomes the camera scroll for this frame.
  assign scroll_clamp = {1'b0, plyr_y_q} < (SCROLL_LINE11 + {7'b0, spd_y_q});
  assign scroll_amt   = SCROLL_LINE10 + {6'b0, spd_y_q} - plyr_y_q;
  assign scroll_dy    = scroll_dy_q;
`else
  assign scroll_dy    = 10'd0;
`endif

  // Next-state and datapath: horizontal motion first, then the phase FSM,
  // which may override x on a restart from DEAD.
  always_comb begin
    state_d  = state_q;
    plyr_x_d = plyr_x_q;
    plyr_y_d = plyr_y_q;
    spd_x_d  = spd_x_q;
    spd_y_d  = spd_y_q;
    gcnt_d   = gcnt_q;
    dir_d    = dir_q;
    bounce_d = 1'b0;
`ifdef JUMP_SCROLL_EN
    scroll_dy_d = 10'd0;
`endif

    if (frame_tick && (state_q == S_RISE || state_q == S_FALL)) begin
      if (btn_left ^ btn_right) begin
        spd_x_d  = X_STEP4;
        dir_d    = btn_right;
        plyr_x_d = btn_right ? x_right : x_left;
      end else begin
        spd_x_d  = 4'd0;
      end
    end

    case (state_q)
      S_IDLE: begin
        // start wins over a coincident frame_tick: launch only, no motion.
        if (start) begin
          state_d = S_RISE;
          spd_y_d = JUMP_V4;
          gcnt_d  = '0;
        end
      end

      S_RISE: begin
        // hit is deliberately ignored while rising.
        if (frame_tick) begin
`ifdef JUMP_SCROLL_EN
          if (scroll_clamp) begin
            plyr_y_d    = SCROLL_LINE10;
            scroll_dy_d = scroll_amt;
          end else begin
            plyr_y_d    = y_rise;
          end
`else
          plyr_y_d = y_rise;
`endif
          if (gcnt_last) begin
            gcnt_d  = '0;
            spd_y_d = spd_y_dec;
            if (spd_y_dec == 4'd0) begin
              state_d = S_FALL;
            end
          end else begin
            gcnt_d = gcnt_inc;
          end
        end
      end

      S_FALL: begin
        if (frame_tick) begin
          if (hit) begin
            // Landing replaces this frame's fall step with a fresh bounce.
            plyr_y_d = y_land;
            spd_y_d  = JUMP_V4;
            gcnt_d   = '0;
            state_d  = S_RISE;
            bounce_d = 1'b1;
          end else if (fall_dead) begin
            plyr_y_d = DEAD_Y10;
            spd_y_d  = 4'd0;
            gcnt_d   = '0;
            state_d  = S_DEAD;
          end else begin
            plyr_y_d = y_fall_sum[9:0];
            if (gcnt_last) begin
              gcnt_d  = '0;
              spd_y_d = spd_y_inc;
            end else begin
              gcnt_d  = gcnt_inc;
            end
          end
        end
      end

      S_DEAD: begin
        // Frozen until a restart, which relaunches from the start position.
        if (start) begin
          plyr_x_d = START_X10;
          plyr_y_d = START_Y10;
          spd_y_d  = JUMP_V4;
          gcnt_d   = '0;
          state_d  = S_RISE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      plyr_x_q <= START_X10;
      plyr_y_q <= START_Y10;
      spd_x_q  <= 4'd0;
      spd_y_q  <= 4'd0;
      gcnt_q   <= '0;
      dir_q    <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      plyr_x_q <= plyr_x_d;
      plyr_y_q <= plyr_y_d;
      spd_x_q  <= spd_x_d;
      spd_y_q  <= spd_y_d;
      gcnt_q   <= gcnt_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
    end
  end

`ifdef JUMP_SCROLL_EN
  // One-cycle camera scroll amount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_dy_q <= 10'd0;
    end else begin
      scroll_dy_q <= scroll_dy_d;
    end
  end
`endif

  assign plyr_x    = plyr_x_q;
  assign plyr_y    = plyr_y_q;
  assign spd_x     = spd_x_q;
  assign spd_y     = spd_y_q;
  assign state     = state_q;
  assign dir       = dir_q;
  assign fly       = (state_q == S_RISE);
  assign bounce    = bounce_q;
  assign game_over = (state_q == S_DEAD);

endmodule

// File: tb/tb_jump_motion_ctrl.sv
// Scoreboard bench for jump_motion_ctrl (default build, JUMP_SCROLL_EN undefined).
module tb_jump_motion_ctrl;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start      = 1'b0;
  logic       btn_left   = 1'b0;
  logic       btn_right  = 1'b0;
  logic       hit        = 1'b0;
  logic [9:0] floor_in   = 10'd0;
  logic [9:0] plyr_x, plyr_y, scroll_dy;
  logic [3:0] spd_x, spd_y;
  logic [1:0] state;
  logic       dir, fly, bounce, game_over;

  always #5 clk = ~clk;

  jump_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .hit        (hit),
    .floor      (floor_in),
    .plyr_x     (plyr_x),
    .plyr_y     (plyr_y),
    .spd_x      (spd_x),
    .spd_y      (spd_y),
    .state      (state),
    .dir        (dir),
    .fly        (fly),
    .bounce     (bounce),
    .game_over  (game_over),
    .scroll_dy  (scroll_dy)
  );

  localparam int M_X = 1, M_Y = 2, M_SX = 4, M_SY = 8, M_ST = 16;
  localparam int M_DIR = 32, M_FLY = 64, M_BNC = 128, M_GO = 256, M_SCR = 512;
  localparam int ALL = 1023;

  typedef struct {
    string name;
    int    mask;
    int    x, y, sx, sy, st, dir, fly, bnc, go, scr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t mk(string name, int mask, int x, int y, int sx, int sy,
                              int st, int d, int f, int b, int g, int s);
    exp_t e;
    e.name = name; e.mask = mask;
    e.x = x; e.y = y; e.sx = sx; e.sy = sy; e.st = st;
    e.dir = d; e.fly = f; e.bnc = b; e.go = g; e.scr = s;
    return e;
  endfunction

  task automatic cmpf(input string nm, input string fld, input logic [31:0] act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
    end
  endtask

  task automatic check_one(output exp_t e);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_underflow: DUT update at %0t with no expectation queued", $time);
      e = mk("none", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    e = sb_q.pop_front();
    if ((e.mask & M_X)   != 0) cmpf(e.name, "plyr_x",    {22'b0, plyr_x},    e.x);
    if ((e.mask & M_Y)   != 0) cmpf(e.name, "plyr_y",    {22'b0, plyr_y},    e.y);
    if ((e.mask & M_SX)  != 0) cmpf(e.name, "spd_x",     {28'b0, spd_x},     e.sx);
    if ((e.mask & M_SY)  != 0) cmpf(e.name, "spd_y",     {28'b0, spd_y},     e.sy);
    if ((e.mask & M_ST)  != 0) cmpf(e.name, "state",     {30'b0, state},     e.st);
    if ((e.mask & M_DIR) != 0) cmpf(e.name, "dir",       {31'b0, dir},       e.dir);
    if ((e.mask & M_FLY) != 0) cmpf(e.name, "fly",       {31'b0, fly},       e.fly);
    if ((e.mask & M_BNC) != 0) cmpf(e.name, "bounce",    {31'b0, bounce},    e.bnc);
    if ((e.mask & M_GO)  != 0) cmpf(e.name, "game_over", {31'b0, game_over}, e.go);
    if ((e.mask & M_SCR) != 0) cmpf(e.name, "scroll_dy", {22'b0, scroll_dy}, e.scr);
    if (e.mask != 0)
      $display("txn %-18s x=%0d y=%0d spd_x=%0d spd_y=%0d state=%0d dir=%0d bounce=%0d go=%0d",
               e.name, plyr_x, plyr_y, spd_x, spd_y, state, dir, bounce, game_over);
  endtask

  // Monitor: every frame_tick/start edge is a DUT update; check it half a cycle later.
  initial begin : tick_monitor
    exp_t pe;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1 && (frame_tick === 1'b1 || start === 1'b1)) begin
        @(negedge clk);
        check_one(pe);
        // bounce is a single-cycle pulse: it must be gone one cycle later.
        if ((pe.mask & M_BNC) != 0 && pe.bnc == 1) begin
          @(negedge clk);
          cmpf({pe.name, "+1"}, "bounce", {31'b0, bounce}, 0);
        end
      end
    end
  end

  // Monitor: reset is asynchronous, so check outputs shortly after rst_n falls.
  initial begin : rst_monitor
    exp_t re;
    forever begin
      @(negedge rst_n);
      #1;
      check_one(re);
    end
  end

  // One transaction: queue expectation, hold inputs for one edge, then idle two cycles.
  task automatic drive(input logic tk, input logic st, input logic bl, input logic br,
                       input logic h, input logic [9:0] fl, input exp_t e);
    sb_q.push_back(e);
    @(negedge clk);
    frame_tick = tk; start = st; btn_left = bl; btn_right = br; hit = h; floor_in = fl;
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0; btn_left = 1'b0; btn_right = 1'b0; hit = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    exp_t e;
    logic bl, br;
    int   wait_cyc;

    // Reset state, checked asynchronously.
    @(negedge clk);
    sb_q.push_back(mk("reset", ALL, 304, 400, 0, 0, 0, 1, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores frame_tick and buttons.
    drive(1, 0, 0, 1, 0, 10'd0, mk("idle_tick", ALL, 304, 400, 0, 0, 0, 1, 0, 0, 0, 0));
    // Launch without a tick: no motion yet.
    drive(0, 1, 0, 0, 0, 10'd0, mk("start", ALL, 304, 400, 0, 12, 1, 1, 1, 0, 0, 0));

    // Flight 1: left held 102 ticks (wraps at x=1), right once (wraps at 638), then both.
    for (int k = 1; k <= 104; k++) begin
      bl = (k <= 102) || (k == 104);
      br = (k >= 103);
      e  = mk("dc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (k)
        1:   e = mk("f1_t1",      ALL, 301, 388, 3, 12, 1, 0, 1, 0, 0, 0);
        4:   e = mk("f1_t4",      M_Y | M_SY | M_ST, 0, 352, 0, 11, 1, 0, 0, 0, 0, 0);
        5:   e = mk("f1_t5",      M_Y | M_SY | M_ST, 0, 341, 0, 11, 1, 0, 0, 0, 0, 0);
        47:  e = mk("f1_t47",     M_Y | M_SY | M_ST, 0, 89, 0, 1, 1, 0, 0, 0, 0, 0);
        48:  e = mk("f1_apex",    ALL, 160, 88, 3, 0, 2, 0, 0, 0, 0, 0);
        52:  e = mk("f1_fall4",   M_Y | M_SY | M_ST, 0, 88, 0, 1, 2, 0, 0, 0, 0, 0);
        53:  e = mk("f1_fall5",   M_Y | M_SY | M_ST, 0, 89, 0, 1, 2, 0, 0, 0, 0, 0);
        56:  e = mk("f1_fall8",   M_Y | M_SY | M_ST, 0, 92, 0, 2, 2, 0, 0, 0, 0, 0);
        101: e = mk("f1_x1",      M_X | M_DIR, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        102: e = mk("f1_wrap_l",  M_X | M_DIR | M_SX, 638, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        103: e = mk("f1_wrap_r",  ALL, 1, 439, 3, 13, 2, 1, 0, 0, 0, 0);
        104: e = mk("f1_death",   ALL, 1, 448, 0, 0, 3, 1, 0, 0, 1, 0);
        default: ;
      endcase
      drive(1, 0, bl, br, 0, 10'd0, e);
    end

    // DEAD freezes motion, then start restarts from the start position.
    drive(1, 0, 0, 1, 0, 10'd0, mk("dead_frozen", ALL, 1, 448, 0, 0, 3, 1, 0, 0, 1, 0));
    drive(0, 1, 0, 0, 0, 10'd0, mk("restart", ALL, 304, 400, 0, 12, 1, 1, 1, 0, 0, 0));

    // Flight 2: start ignored while rising, then land on a platform.
    drive(1, 0, 0, 0, 0, 10'd0, mk("f2_t1", ALL, 304, 388, 0, 12, 1, 1, 1, 0, 0, 0));
    drive(0, 1, 0, 0, 0, 10'd0, mk("start_in_rise", ALL, 304, 388, 0, 12, 1, 1, 1, 0, 0, 0));
    for (int k = 2; k <= 56; k++) begin
      e = mk("dc", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (k == 48) e = mk("f2_apex",  ALL, 304, 88, 0, 0, 2, 1, 0, 0, 0, 0);
      if (k == 56) e = mk("f2_fall8", ALL, 304, 92, 0, 2, 2, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 10'd0, e);
    end
    drive(1, 0, 0, 0, 1, 10'd300, mk("land", ALL, 304, 268, 0, 12, 1, 1, 1, 1, 0, 0));
    drive(1, 0, 1, 0, 1, 10'd100, mk("rise_ignores_hit", ALL, 301, 256, 3, 12, 1, 0, 1, 0, 0, 0));

    // Asynchronous reset mid-RISE, between ticks.
    sb_q.push_back(mk("async_reset", ALL, 304, 400, 0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // start and frame_tick together: start wins, no motion that cycle.
    drive(1, 1, 1, 0, 0, 10'd0, mk("start_with_tick", ALL, 304, 400, 0, 12, 1, 1, 1, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 10'd0, mk("post_start_tick", ALL, 304, 388, 0, 12, 1, 1, 1, 0, 0, 0));

    // Drain the scoreboard (bounded).
    wait_cyc = 0;
    while (sb_q.size() != 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
